// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch sequencer: fetches an instruction over a req/ack
// handshake, issues it to decode, waits for execute, then pulses the PC load
// enable with the branch/increment select. Counts retired instructions and
// latches a sticky fault if instruction memory stops answering.
module pc_fetch_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             branch_taken,
  input  logic             stall,
  output logic             pc_en,
  output logic             pc_src,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_UPDATE,
    S_FAULT
  } state_t;

  state_t            state;
  logic              br_q;
  logic [WAIT_W-1:0] wait_cnt;

  // Sequencer state, fetched instruction, branch select, wait and retire counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      instr    <= '0;
      br_q     <= 1'b0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!stall) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          // An ack on the last permitted cycle takes priority over the timeout.
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= S_ISSUE;
          end else begin
            if (wait_cnt != WAIT_MAX) begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (wait_cnt >= WAIT_LAST) begin
              state <= S_FAULT;
            end
          end
        end
        S_ISSUE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_done) begin
            br_q  <= branch_taken;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!stall) begin
            retired  <= retired + CNT_W'(1);
            wait_cnt <= '0;
            state    <= S_FETCH;
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the state register; pc_en also follows stall directly
  always_comb begin
    imem_req    = (state == S_FETCH);
    instr_valid = (state == S_ISSUE);
    pc_en       = (state == S_UPDATE) && !stall;
    pc_src      = (state == S_UPDATE) ? br_q : 1'b0;
    fault       = (state == S_FAULT);
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed instruction sequences with a behavioural
// instruction-lifecycle model checked every cycle, plus literal expectations.
module tb_pc_fetch_ctrl;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             imem_req;
  logic             imem_ack = 1'b0;
  logic [WIDTH-1:0] imem_rdata = '0;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             exec_done = 1'b0;
  logic             branch_taken = 1'b0;
  logic             stall = 1'b0;
  logic             pc_en;
  logic             pc_src;
  logic [CNT_W-1:0] retired;
  logic             fault;

  int total  = 0;
  int passed = 0;
  int exp_retired = 0;
  bit compare_en = 1'b0;

  pc_fetch_ctrl #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .branch_taken(branch_taken),
    .stall       (stall),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .retired     (retired),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Lifecycle phase of the current instruction.
  localparam int P_IDLE = 0, P_FETCH = 1, P_ISSUE = 2, P_EXEC = 3, P_UPDATE = 4, P_DEAD = 5;
  int          m_phase   = P_IDLE;
  int          m_waited  = 0;
  logic [31:0] m_instr   = '0;
  logic        m_br      = 1'b0;
  int          m_retired = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase   <= P_IDLE;
      m_waited  <= 0;
      m_instr   <= '0;
      m_br      <= 1'b0;
      m_retired <= 0;
    end else begin
      if (m_phase == P_IDLE && !stall) begin
        m_phase  <= P_FETCH;
        m_waited <= 0;
      end else if (m_phase == P_FETCH) begin
        if (imem_ack) begin
          m_instr <= imem_rdata;
          m_phase <= P_ISSUE;
        end else begin
          m_waited <= m_waited + 1;
          if (m_waited + 1 == TIMEOUT) m_phase <= P_DEAD;
        end
      end else if (m_phase == P_ISSUE) begin
        m_phase <= P_EXEC;
      end else if (m_phase == P_EXEC && exec_done) begin
        m_br    <= branch_taken;
        m_phase <= P_UPDATE;
      end else if (m_phase == P_UPDATE && !stall) begin
        m_retired <= (m_retired + 1) % (1 << CNT_W);
        m_phase   <= P_FETCH;
        m_waited  <= 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (compare_en) begin
      check("m_imem_req", imem_req, (m_phase == P_FETCH));
      check("m_instr_valid", instr_valid, (m_phase == P_ISSUE));
      check("m_instr", instr, m_instr);
      check("m_pc_en", pc_en, (m_phase == P_UPDATE) && !stall);
      check("m_pc_src", pc_src, (m_phase == P_UPDATE) ? m_br : 1'b0);
      check("m_retired", retired, m_retired);
      check("m_fault", fault, (m_phase == P_DEAD));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: fetch with wait_cyc ack-less cycles, exec after
  // exec_dly cycles, stall held stall_cyc cycles on entering UPDATE.
  task automatic run_instr(input logic [31:0] data, input int unsigned wait_cyc,
                           input logic br, input int unsigned stall_cyc,
                           input int unsigned exec_dly);
    int unsigned n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("fetch_start", imem_req, 1'b1);
    exec_done = 1'b1;   // ignored outside EXEC
    repeat (wait_cyc) tick();
    exec_done  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("issue_valid", instr_valid, 1'b1);
    check("issue_instr", instr, data);
    check("issue_no_fault", fault, 1'b0);
    tick();
    check("exec_valid_low", instr_valid, 1'b0);
    repeat (exec_dly) tick();
    exec_done    = 1'b1;
    branch_taken = br;
    tick();
    exec_done    = 1'b0;
    branch_taken = ~br;  // select must come from the value captured with exec_done
    for (int unsigned s = 0; s < stall_cyc; s++) begin
      stall = 1'b1;
      #1;
      check("stall_pc_en", pc_en, 1'b0);
      tick();
    end
    stall = 1'b0;
    #1;
    check("upd_pc_en", pc_en, 1'b1);
    check("upd_pc_src", pc_src, br);
    tick();
    exp_retired = (exp_retired + 1) % (1 << CNT_W);
    check("retired_cnt", retired, exp_retired);
    check("post_pc_en", pc_en, 1'b0);
  endtask

  initial begin
    #2 rst = 1'b0;
    compare_en = 1'b1;
    tick();
    tick();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_pc_src", pc_src, 1'b0);
    check("rst_retired", retired, 0);
    check("rst_fault", fault, 1'b0);
    rst = 1'b1;
    check("idle_after_rst", imem_req, 1'b0);

    // Minimum-period instruction
    run_instr(32'h0050_0093, 0, 1'b0, 0, 0);
    check("first_retired", retired, 1);
    // Branch taken, then not taken
    run_instr(32'h0000_0463, 2, 1'b1, 0, 1);
    run_instr(32'h0010_0113, 0, 1'b0, 0, 0);
    // Stall held three cycles in UPDATE
    run_instr(32'h0020_8193, 1, 1'b1, 3, 2);
    // Ack on the last permitted wait cycle
    run_instr(32'hABCD_0001, TIMEOUT - 1, 1'b0, 0, 0);
    check("edge_ack_retired", retired, 5);
    // Run the counter to wrap
    for (int unsigned i = 0; i < 11; i++) run_instr(32'h1000_0000 + i, i % 3, i[0], i % 2, 0);
    check("retired_wrap", retired, 0);

    // Fetch timeout
    check("to_req", imem_req, 1'b1);
    repeat (TIMEOUT - 1) tick();
    check("to_pre_fault", fault, 1'b0);
    check("to_pre_req", imem_req, 1'b1);
    tick();
    check("to_fault", fault, 1'b1);
    check("to_req_low", imem_req, 1'b0);
    imem_ack  = 1'b1;
    exec_done = 1'b1;
    repeat (3) tick();
    check("to_sticky", fault, 1'b1);
    check("to_ignore_ack", instr_valid, 1'b0);
    check("to_ignore_exec", pc_en, 1'b0);
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    rst = 1'b0;
    exp_retired = 0;
    #1;
    check("to_rst_fault", fault, 1'b0);
    tick();
    rst = 1'b1;

    // Asynchronous reset in the middle of EXEC
    run_instr(32'h0000_0013, 0, 1'b1, 0, 0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    tick();
    check("mid_exec_instr", instr, 32'h1234_5678);
    #2 rst = 1'b0;
    #1;
    check("async_instr", instr, 32'h0);
    check("async_retired", retired, 0);
    check("async_req", imem_req, 1'b0);
    check("async_valid", instr_valid, 1'b0);
    check("async_pc_en", pc_en, 1'b0);
    check("async_fault", fault, 1'b0);
    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Multi-cycle sequencer for the program-counter datapath. It fetches each instruction from instruction memory over a req/ack handshake and hands it to decode. It waits for execution to finish, then pulses the PC register's load enable with the branch/increment select (`pc_src`) that chooses between PC+4 and PC+ImmOp. It also counts retired instructions and raises a sticky fault if instruction memory stops responding.

## Interface
Parameters:
- WIDTH, 32, instruction/data width
- TIMEOUT, 15, max cycles `imem_req` may wait for `imem_ack` before fault (1..255)
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- imem_req  out  1  fetch request to instruction memory
- imem_ack  in  1  memory response; `imem_rdata` valid this cycle
- imem_rdata  in  WIDTH  fetched instruction
- instr  out  WIDTH  registered instruction to decode
- instr_valid  out  1  one-cycle pulse: `instr` is new
- exec_done  in  1  execute stage finished current instruction
- branch_taken  in  1  sampled only with `exec_done`; 1 = take branch
- stall  in  1  hold PC update / fetch start while 1
- pc_en  out  1  load enable for PC register
- pc_src  out  1  0 = PC+4, 1 = PC+ImmOp; meaningful only when `pc_en`=1
- retired  out  CNT_W  instructions retired since reset
- fault  out  1  sticky fetch-timeout flag

## Operation
- States:
  - IDLE → FETCH when `stall`=0; otherwise stay in IDLE.
  - FETCH: `imem_req`=1. On `imem_ack`=1, latch `imem_rdata` into `instr` and go to ISSUE. Otherwise increment the wait counter.
    - If the wait counter reaches TIMEOUT with no ack, go to FAULT.
  - ISSUE: `instr_valid`=1 for exactly one cycle → EXEC.
  - EXEC: wait for `exec_done`=1.
    - On `exec_done`, latch `branch_taken` into `br_q` and go to UPDATE.
    - `exec_done` is ignored in every other state.
  - UPDATE:
    - If `stall`=1: `pc_en`=0, stay in UPDATE.
    - If `stall`=0: `pc_en`=1, `pc_src`=`br_q`, `retired`+=1, go to FETCH.
  - FAULT: terminal until reset. `fault`=1 and `imem_req`=0; `exec_done` and `imem_ack` are ignored.
- Output decoding:
  - `pc_en` = (state==UPDATE) & ~`stall`, which is combinational on `stall`.
  - `pc_src` = `br_q` when in UPDATE, else 0.
  - `imem_req` is decoded from state (FETCH only).
- Wait counter: width clog2(TIMEOUT+1). Cleared on every entry to FETCH; saturates and does not wrap.
- `retired` wraps modulo 2^CNT_W (all-ones → 0) with no flag.
- `instr` holds its value until the next accepted fetch.
- `br_q` holds its value until the next `exec_done`.

## Timing
- Reset (rst=0, asynchronous, takes effect immediately, including mid-fetch or mid-UPDATE):
  - state=IDLE.
  - `imem_req`=0, `instr`=0, `instr_valid`=0, `pc_en`=0, `pc_src`=0, `retired`=0, `fault`=0.
  - `br_q`=0, wait counter=0.
- First cycle after rst rises: IDLE. Next cycle: FETCH (if `stall`=0).
- Ack in the first FETCH cycle gives a minimum instruction period of 4 cycles: FETCH, ISSUE, EXEC, UPDATE.
  - `exec_done` arriving in the first EXEC cycle is accepted.
- `instr_valid` rises on the cycle after the ack edge. `instr` is stable in that same cycle.
- Timeout: ack-less cycles in FETCH are counted. On the TIMEOUT-th ack-less cycle, the next state is FAULT.
  - An ack arriving on that same cycle wins: the fetch completes and no fault is raised.
- `stall` rising during UPDATE suppresses `pc_en` that same cycle; the update completes in the first cycle with `stall`=0.
- `stall` has no effect in FETCH, ISSUE or EXEC. An outstanding request is never withdrawn.

## Test plan
- Reset release, `stall`=0, ack on the 1st FETCH cycle with `imem_rdata`=0x00500093, `exec_done` 1 cycle after `instr_valid`, `branch_taken`=0 → `instr`=0x00500093, one `instr_valid` pulse, `pc_en`=1/`pc_src`=0 on the 4th cycle after IDLE, `retired`=1.
- Branch: `branch_taken`=1 with `exec_done` → the UPDATE cycle shows `pc_en`=1, `pc_src`=1. Next instruction with `branch_taken`=0 → `pc_src`=0.
- `stall`=1 for 3 cycles on entering UPDATE → `pc_en`=0 for 3 cycles, then exactly one `pc_en` pulse, `retired` incremented once.
- No ack for TIMEOUT=15 cycles → `fault`=1 and `imem_req`=0 from then on; later `imem_ack`/`exec_done` ignored. rst=0 clears `fault`.
- Ack exactly on the 15th wait cycle → no fault, ISSUE follows.
- Preload `retired` to all-ones by running 2^CNT_W instructions (or CNT_W=4 with 16 instructions) → wraps to 0. Asserting rst=0 mid-EXEC → all outputs return to reset values immediately, without waiting for a clock edge.
